fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory read port, decode-side handshake and branch redirect.
// The fetch unit takes the master view; memory, decode and branch logic take the slave view.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr, opcode, pc_out, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, pc_out, instr_valid,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait for ack, hold the word for decode,
// and drop in-flight responses after a branch/jump redirect.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | issue one-cycle imem_req at PC
// ST_WAIT  | request outstanding, word goes to decode on ack
// ST_HOLD  | instruction presented to decode until accepted or redirected
// ST_DRAIN | request outstanding but stale, its response is discarded
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;

        unique case (state_q)
            ST_FETCH: begin
                if (bus.redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = bus.imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (bus.imem_ack) begin
                    instr_d  = bus.imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = ST_FETCH;
                end else if (bus.instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // The stale response must still be absorbed before a new request may go out.
                if (bus.redirect) begin
                    pc_d = redirect_tgt;
                end
                if (bus.imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Gated by rst so no request escapes while reset is still held.
    assign bus.imem_req    = (state_q == ST_FETCH) && !rst;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.pc_out      = pc_out_q;
    assign bus.instr_valid = (state_q == ST_HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-computed expectations for throughput, stall,
// redirect in each state, PC wrap and mid-operation reset.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   c0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // From FETCH: step into WAIT, return a 1-cycle ack, land in HOLD.
    task automatic serve(input logic [31:0] data);
        tick;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        tick;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        tick; tick; tick;

        check_eq("rst_req",   {31'd0, bus.imem_req},    32'd0);
        check_eq("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check_eq("rst_instr", bus.instr,                32'd0);
        check_eq("rst_opc",   {26'd0, bus.opcode},      32'd0);
        check_eq("rst_pcout", bus.pc_out,               32'd0);
        check_eq("rst_addr",  bus.imem_addr,            32'd0);

        // Basic flow and 3-cycle throughput
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        check_eq("first_req",  {31'd0, bus.imem_req}, 32'd1);
        check_eq("first_addr", bus.imem_addr,         32'd0);
        c0 = cyc;
        tick;
        check_eq("wait_noreq", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h8C22_0004;
        tick;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        check_eq("t1_valid", {31'd0, bus.instr_valid}, 32'd1);
        check_eq("t1_instr", bus.instr,                32'h8C22_0004);
        check_eq("t1_opc",   {26'd0, bus.opcode},      32'h23);
        check_eq("t1_pcout", bus.pc_out,               32'h0);
        tick;
        check_eq("t1_req",   {31'd0, bus.imem_req},    32'd1);
        check_eq("t1_addr",  bus.imem_addr,            32'h4);
        check_eq("t1_thru",  cyc - c0,                 32'd3);
        check_eq("t1_vlow",  {31'd0, bus.instr_valid}, 32'd0);

        c0 = cyc;
        serve(32'h0043_2020);
        check_eq("t1b_pcout", bus.pc_out,          32'h4);
        check_eq("t1b_opc",   {26'd0, bus.opcode}, 32'h0);
        tick;
        check_eq("t1b_addr",  bus.imem_addr,       32'h8);
        check_eq("t1b_thru",  cyc - c0,            32'd3);

        // Stall in HOLD; acks arriving in HOLD must be ignored
        bus.instr_ready = 1'b0;
        serve(32'h2001_0008);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
            check_eq("stall_instr", bus.instr,                32'h2001_0008);
            check_eq("stall_pcout", bus.pc_out,               32'h8);
            check_eq("stall_req",   {31'd0, bus.imem_req},    32'd0);
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'hBAD0_0000 + i;
            tick;
        end
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        check_eq("stall_end_instr", bus.instr, 32'h2001_0008);
        bus.instr_ready = 1'b1;
        tick;
        check_eq("stall_req2",  {31'd0, bus.imem_req}, 32'd1);
        check_eq("stall_addr2", bus.imem_addr,         32'hC);

        // Redirect in WAIT without ack, ack two cycles later is dropped
        tick;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        tick;
        bus.redirect = 1'b0;
        check_eq("drain_req",   {31'd0, bus.imem_req},    32'd0);
        check_eq("drain_valid", {31'd0, bus.instr_valid}, 32'd0);
        tick;
        check_eq("drain_req2",  {31'd0, bus.imem_req},    32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        check_eq("rw_valid", {31'd0, bus.instr_valid}, 32'd0);
        check_eq("rw_req",   {31'd0, bus.imem_req},    32'd1);
        check_eq("rw_addr",  bus.imem_addr,            32'h100);
        check_eq("rw_instr", bus.instr,                32'h2001_0008);

        // Redirect in FETCH to 0x40, then redirect+ready together in HOLD
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        tick;
        bus.redirect   = 1'b0;
        check_eq("rf_req", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1111_1111;
        tick;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        check_eq("rf_addr", bus.imem_addr, 32'h40);
        serve(32'hAC43_0010);
        check_eq("rh_pcout", bus.pc_out,          32'h40);
        check_eq("rh_opc",   {26'd0, bus.opcode}, 32'h2B);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0203;
        tick;
        bus.redirect = 1'b0;
        check_eq("rh_addr",  bus.imem_addr,            32'h200);
        check_eq("rh_valid", {31'd0, bus.instr_valid}, 32'd0);

        // PC wrap from 0xFFFF_FFFC
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFF;
        tick;
        bus.redirect   = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h2222_2222;
        tick;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        check_eq("wrap_pre", bus.imem_addr, 32'hFFFF_FFFC);
        serve(32'h0800_0000);
        check_eq("wrap_pcout", bus.pc_out,          32'hFFFF_FFFC);
        check_eq("wrap_opc",   {26'd0, bus.opcode}, 32'h02);
        tick;
        check_eq("wrap_req",  {31'd0, bus.imem_req}, 32'd1);
        check_eq("wrap_addr", bus.imem_addr,         32'h0);

        // Redirect in WAIT together with ack: data dropped, straight back to FETCH
        tick;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0080;
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 32'hFFFF_FFFF;
        tick;
        bus.redirect   = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        check_eq("rwa_req",   {31'd0, bus.imem_req},    32'd1);
        check_eq("rwa_addr",  bus.imem_addr,            32'h80);
        check_eq("rwa_valid", {31'd0, bus.instr_valid}, 32'd0);
        check_eq("rwa_instr", bus.instr,                32'h0800_0000);

        // Reset during WAIT, with competing ack/ready/redirect
        tick;
        rst             = 1'b1;
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 32'h3333_3333;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0400;
        tick;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.redirect   = 1'b0;
        check_eq("mrst_req",   {31'd0, bus.imem_req},    32'd0);
        check_eq("mrst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check_eq("mrst_instr", bus.instr,                32'd0);
        check_eq("mrst_opc",   {26'd0, bus.opcode},      32'd0);
        check_eq("mrst_pcout", bus.pc_out,               32'd0);
        check_eq("mrst_addr",  bus.imem_addr,            32'd0);
        rst = 1'b0;
        #1;
        check_eq("mrst_req2",  {31'd0, bus.imem_req}, 32'd1);
        check_eq("mrst_addr2", bus.imem_addr,         32'd0);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
